// File: rtl/natural_from_sum_pkg.sv
// Shared constants and state encoding for the natural_from_sum block.
// Optional remainder output is enabled with the NFS_REM_EN macro.
package nfs_pkg;

    localparam int unsigned SW_DEF = 7;
    localparam int unsigned NW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/natural_from_sum_step.sv
// Combinational step for natural_from_sum: compares acc against k and forms acc-k.
// Used identically whether or not NFS_REM_EN is defined.
module nfs_step
    import nfs_pkg::*;
#(
    parameter int unsigned SW = SW_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic [SW-1:0] acc,
    input  logic [NW:0]   k,
    output logic          ge,
    output logic [SW-1:0] diff
);

    localparam int unsigned W = (SW > NW + 1) ? SW : NW + 1;

    logic [W-1:0] acc_x;
    logic [W-1:0] k_x;

    always_comb begin
        acc_x = W'(acc);
        k_x   = W'(k);
        ge    = (acc_x >= k_x);
        // only consumed when ge holds, so k fits in SW bits there
        diff  = acc - SW'(k);
    end

endmodule

// File: rtl/natural_from_sum.sv
// Finds the largest n with 1+2+...+n <= s by subtracting k=1,2,... one per clock.
// Define NFS_REM_EN to add the rem output (s - T(n)).
module natural_from_sum
    import nfs_pkg::*;
#(
    parameter int unsigned SW = SW_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [SW-1:0] s,
    output logic [NW-1:0] n,
    output logic          busy,
    output logic          done,
    output logic          exact
`ifdef NFS_REM_EN
    ,
    output logic [SW-1:0] rem
`endif
);

    state_t        state, state_n;
    logic [SW-1:0] acc, acc_n;
    logic [NW:0]   k, k_n;
    logic [NW:0]   km1;
    logic [NW-1:0] n_n;
    logic          busy_n, done_n, exact_n;
    logic          ge;
    logic [SW-1:0] diff;

    nfs_step #(
        .SW (SW),
        .NW (NW)
    ) u_step (
        .acc  (acc),
        .k    (k),
        .ge   (ge),
        .diff (diff)
    );

`ifdef NFS_REM_EN
    logic [SW-1:0] rem_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            k     <= (NW + 1)'(1);
            n     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            exact <= 1'b0;
`ifdef NFS_REM_EN
            rem   <= '0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            k     <= k_n;
            n     <= n_n;
            busy  <= busy_n;
            done  <= done_n;
            exact <= exact_n;
`ifdef NFS_REM_EN
            rem   <= rem_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        k_n     = k;
        n_n     = n;
        busy_n  = busy;
        done_n  = done;
        exact_n = exact;
`ifdef NFS_REM_EN
        rem_n   = rem;
`endif
        km1     = k - 1'b1;
        case (state)
            IDLE, DONE: begin
                if (init) begin
                    acc_n   = s;
                    k_n     = (NW + 1)'(1);
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    exact_n = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (ge) begin
                    acc_n = diff;
                    k_n   = k + 1'b1;
                end else begin
                    // what is left in acc is exactly s - T(k-1)
                    n_n     = km1[NW-1:0];
                    exact_n = (acc == '0);
`ifdef NFS_REM_EN
                    rem_n   = acc;
`endif
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_natural_from_sum.sv
// Directed self-checking bench for natural_from_sum (vector table plus corner sequences).
module tb_natural_from_sum;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic [6:0] s;
    logic [3:0] n;
    logic       busy;
    logic       done;
    logic       exact;
`ifdef NFS_REM_EN
    logic [6:0] rem;
`endif

    int tests = 0;
    int fails = 0;

    natural_from_sum #(
        .SW (7),
        .NW (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .init  (init),
        .s     (s),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .exact (exact)
`ifdef NFS_REM_EN
        ,
        .rem   (rem)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [6:0] s;
        int         exp_n;
        int         exp_exact;
        int         exp_rem;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [6:0] sv);
        @(negedge clk);
        s    = sv;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    // counts edges after the accepted init until done reads high
    task automatic wait_done(input int already, output int lat, output int busy_gaps);
        lat = already;
        busy_gaps = 0;
        while (!done && lat < 200) begin
            if (!busy) busy_gaps++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int exp_n, input int exp_exact,
                                input int exp_rem, input int exp_lat, input int lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " done"}, {31'd0, done}, 1);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " n"}, {28'd0, n}, exp_n);
        chk({tag, " exact"}, {31'd0, exact}, exp_exact);
`ifdef NFS_REM_EN
        chk({tag, " rem"}, {25'd0, rem}, exp_rem);
`else
        if (exp_rem < 0) $display("unexpected remainder %0d", exp_rem);
`endif
    endtask

    vec_t vecs[7];

    initial begin
        int lat, gaps;
        logic [3:0] n_hold;

        vecs[0] = '{7'd45,  9,  1, 0, 10};
        vecs[1] = '{7'd50,  9,  0, 5, 10};
        vecs[2] = '{7'd0,   0,  1, 0, 1};
        vecs[3] = '{7'd127, 15, 0, 7, 16};
        vecs[4] = '{7'd1,   1,  1, 0, 2};
        vecs[5] = '{7'd2,   1,  0, 1, 2};
        vecs[6] = '{7'd6,   3,  1, 0, 4};

        rst  = 1'b1;
        init = 1'b1;
        s    = 7'd99;
        repeat (3) @(posedge clk);
        #1;
        chk("reset n", {28'd0, n}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset exact", {31'd0, exact}, 0);
`ifdef NFS_REM_EN
        chk("reset rem", {25'd0, rem}, 0);
`endif
        @(negedge clk);
        init = 1'b0;
        rst  = 1'b0;

        // table vectors, each started the cycle after the previous done
        for (int i = 0; i < 7; i++) begin
            start(vecs[i].s);
            chk($sformatf("vec%0d busy on accept", i), {31'd0, busy}, vecs[i].exp_lat > 0 ? 1 : 0);
            chk($sformatf("vec%0d done cleared", i), {31'd0, done}, 0);
            wait_done(0, lat, gaps);
            chk($sformatf("vec%0d busy gaps", i), gaps, 0);
            check_result($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_exact,
                         vecs[i].exp_rem, vecs[i].exp_lat, lat);
        end

        // done is a level: result stays put while idle
        n_hold = n;
        repeat (4) @(posedge clk);
        #1;
        chk("hold done", {31'd0, done}, 1);
        chk("hold n", {28'd0, n}, {28'd0, n_hold});
        chk("hold exact", {31'd0, exact}, 1);

        // second init during RUN is ignored
        start(7'd120);
        repeat (4) @(posedge clk);
        @(negedge clk);
        s    = 7'd3;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        wait_done(5, lat, gaps);
        check_result("ignore init", 15, 1, 0, 16, lat);

        // reset mid-computation aborts without done
        start(7'd100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        chk("abort n", {28'd0, n}, 0);
        chk("abort exact", {31'd0, exact}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort stays idle", {31'd0, done | busy}, 0);
        start(7'd6);
        wait_done(0, lat, gaps);
        check_result("after abort", 3, 1, 0, 4, lat);

        // loop-back: forward sum T(k) must invert to k exactly
        for (int k = 0; k < 16; k++) begin
            start(7'(k * (k + 1) / 2));
            wait_done(0, lat, gaps);
            check_result($sformatf("loop%0d", k), k, 1, 0, k + 1, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
